// File: rtl/ram_rd_stream.sv
// ram_rd_stream
//   Read-side sequencer for a registered-read SRAM macro. It accepts a
//   burst command (start address, word count) and drives the SRAM read port.
//   The SRAM returns each word one cycle after the read. Returned words go
//   into a 2-entry skid buffer, which feeds a valid/ready output stream, so
//   the consumer may stall at any time without words being lost or repeated.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready   burst command handshake (ready only when idle)
//   cmd_addr, cmd_len     first word address and word count (0 is legal)
//   read_en, addr_r       SRAM read request and address
//   ram_data              SRAM read data, valid the cycle after read_en
//   out_valid/out_ready   output stream handshake
//   out_data, out_last    stream word and end-of-burst marker
//   busy                  high whenever the sequencer is not idle
//   done                  one-cycle pulse once the burst has fully drained
module ram_rd_stream #(
    parameter int SRAM_ADDR_WIDTH = 10,
    parameter int SRAM_WIDTH      = 64,
    parameter int LEN_WIDTH       = SRAM_ADDR_WIDTH + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [SRAM_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]       cmd_len,
    output logic                       read_en,
    output logic [SRAM_ADDR_WIDTH-1:0] addr_r,
    input  logic [SRAM_WIDTH-1:0]      ram_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SRAM_WIDTH-1:0]      out_data,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [SRAM_ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]       issue_left;
    logic [LEN_WIDTH-1:0]       beat_left;
    logic [1:0]                 occ;
    logic                       inflight;
    logic                       head;
    logic [SRAM_WIDTH-1:0]      skid_mem [2];

    logic                       cmd_fire;
    logic                       pop;
    logic [2:0]                 fill;

    assign cmd_ready = (state == IDLE);
    assign cmd_fire  = cmd_valid & cmd_ready;
    assign out_valid = (occ != 2'd0);
    assign pop       = out_valid & out_ready;

    // Words already buffered, plus the word still in the SRAM pipe, minus
    // the word leaving this cycle. A new read may only be issued while this
    // is below 2, so its data always finds a free buffer slot.
    assign fill    = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign read_en = (state == READ) && (fill < 3'd2);
    assign addr_r  = addr_q;

    // The output is masked to zero when the buffer is empty, so out_data
    // reads 0 after reset even though the buffer storage is not reset.
    assign out_data = out_valid ? skid_mem[head] : '0;
    assign out_last = out_valid && (beat_left == LEN_WIDTH'(1));
    assign done     = (state == DONE);
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_fire) begin
                    state_nxt = (cmd_len == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (read_en && (issue_left == LEN_WIDTH'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            issue_left <= '0;
            beat_left  <= '0;
            occ        <= 2'd0;
            inflight   <= 1'b0;
            head       <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= read_en;
            occ      <= occ + {1'b0, inflight} - {1'b0, pop};
            head     <= head ^ pop;

            if (cmd_fire) begin
                addr_q     <= cmd_addr;
                issue_left <= cmd_len;
                beat_left  <= cmd_len;
            end else begin
                if (read_en) begin
                    addr_q     <= addr_q + SRAM_ADDR_WIDTH'(1);
                    issue_left <= issue_left - LEN_WIDTH'(1);
                end
                if (pop) begin
                    beat_left <= beat_left - LEN_WIDTH'(1);
                end
            end
        end
    end

    // Buffer storage carries data only and is not reset. A word is pushed
    // only while occ is 0 or 1, so the tail slot is head when occ is 0 and
    // the other slot when occ is 1.
    always_ff @(posedge clk) begin
        if (inflight) begin
            skid_mem[head ^ occ[0]] <= ram_data;
        end
    end

endmodule

// File: tb/tb_ram_rd_stream.sv
module tb_ram_rd_stream;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_addr;
    logic [10:0] cmd_len;
    logic        read_en;
    logic [9:0]  addr_r;
    logic [63:0] ram_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    int n_assert = 0;
    int n_fail   = 0;

    logic [63:0] ram [1024];

    ram_rd_stream #(
        .SRAM_ADDR_WIDTH(10),
        .SRAM_WIDTH(64),
        .LEN_WIDTH(11)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr),
        .cmd_len(cmd_len),
        .read_en(read_en),
        .addr_r(addr_r),
        .ram_data(ram_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read SRAM model: data for the address presented with
    // read_en appears on the following cycle.
    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i] = 64'hD000_0000_0000_0000 | 64'(i);
        end
        ram_data = '0;
    end

    always @(posedge clk) begin
        if (read_en) ram_data <= ram[addr_r];
    end

    function automatic logic [63:0] word_at(input logic [9:0] a);
        return 64'hD000_0000_0000_0000 | {54'd0, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one burst with out_ready held high, starting at a negedge of an
    // idle cycle T, and checks every cycle T+1 .. T+len+4 against the
    // expected timeline. At T+1 the command inputs switch to (nv, na, nl).
    task automatic burst(input logic [9:0] a, input int len,
                         input logic nv, input logic [9:0] na, input int nl);
        logic [9:0] ea;
        out_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = 11'(len);
        for (int c = 1; c <= len + 4; c++) begin
            @(negedge clk);
            if (c == 1) begin
                cmd_valid = nv;
                cmd_addr  = na;
                cmd_len   = 11'(nl);
            end
            #1;
            if (c <= len + 3) begin
                chk("cmd_ready_low", cmd_ready, 0);
                chk("busy_high", busy, 1);
                chk("read_en", read_en, (c <= len));
                if (c <= len) begin
                    ea = a + 10'(c - 1);
                    chk("addr_r", addr_r, ea);
                end
                chk("out_valid", out_valid, (c >= 3 && c <= len + 2));
                if (c >= 3 && c <= len + 2) begin
                    ea = a + 10'(c - 3);
                    chk("out_data", out_data, word_at(ea));
                    chk("out_last", out_last, (c == len + 2));
                end
                chk("done", done, (c == len + 3));
            end else begin
                chk("cmd_ready_back", cmd_ready, 1);
                chk("done_cleared", done, 0);
                chk("busy_cleared", busy, 0);
                chk("out_valid_idle", out_valid, 0);
            end
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_read_en"}, read_en, 0);
        chk({tag, "_addr_r"}, addr_r, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_occ"}, dut.occ, 0);
        chk({tag, "_inflight"}, dut.inflight, 0);
    endtask

    initial begin
        int beats;
        int stall;
        int phase;
        logic got_done;
        logic hold;
        logic [63:0] held;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        out_ready = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk_reset_values("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic burst: 0x010, 4 words
        burst(10'h010, 4, 1'b0, 10'h000, 0);

        // Address wrap: 0x3FE, 0x3FF, 0x000, 0x001
        burst(10'h3FE, 4, 1'b0, 10'h000, 0);

        // Zero length
        cmd_valid = 1'b1;
        cmd_addr  = 10'h055;
        cmd_len   = 11'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk("zl_done", done, 1);
        chk("zl_busy", busy, 1);
        chk("zl_read_en", read_en, 0);
        chk("zl_out_valid", out_valid, 0);
        chk("zl_cmd_ready", cmd_ready, 0);
        @(negedge clk);
        #1;
        chk("zl_done_end", done, 0);
        chk("zl_cmd_ready_back", cmd_ready, 1);
        chk("zl_read_en_end", read_en, 0);
        chk("zl_out_valid_end", out_valid, 0);

        // Backpressure: 16 words from 0x200, stall 5 cycles after beat 3,
        // then random ready
        cmd_valid = 1'b1;
        cmd_addr  = 10'h200;
        cmd_len   = 11'd16;
        beats     = 0;
        stall     = 0;
        phase     = 0;
        got_done  = 1'b0;
        hold      = 1'b0;
        held      = '0;
        for (int k = 0; k < 300 && !got_done; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (phase == 1) begin
                out_ready = 1'b0;
                stall--;
                if (stall == 0) phase = 2;
            end else if (phase == 2) begin
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                out_ready = 1'b1;
            end
            #1;
            chk("bp_occ_inflight_max2", ((dut.occ + dut.inflight) <= 2), 1);
            if (hold) begin
                chk("bp_stall_valid", out_valid, 1);
                chk("bp_stall_data", out_data, held);
            end
            if (done) got_done = 1'b1;
            if (out_valid && out_ready) begin
                chk("bp_data", out_data, word_at(10'h200 + 10'(beats)));
                chk("bp_last", out_last, (beats == 15));
                beats++;
                if (beats == 3) begin
                    phase = 1;
                    stall = 5;
                end
            end
            hold = out_valid && !out_ready;
            held = out_data;
        end
        out_ready = 1'b1;
        chk("bp_beat_count", beats, 16);
        chk("bp_done_seen", got_done, 1);
        @(negedge clk);
        #1;
        chk("bp_cmd_ready_back", cmd_ready, 1);

        // Reset during beat 5 of a 10-word burst
        cmd_valid = 1'b1;
        cmd_addr  = 10'h300;
        cmd_len   = 11'd10;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) cmd_valid = 1'b0;
        end
        #1;
        chk("mr_beat5_valid", out_valid, 1);
        chk("mr_beat5_data", out_data, word_at(10'h304));
        rst_n = 1'b0;
        #1;
        chk_reset_values("mr");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("mr_no_beat_after_release", out_valid, 0);
            chk("mr_no_read_after_release", read_en, 0);
        end
        burst(10'h100, 2, 1'b0, 10'h000, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("mr_no_extra_beat", out_valid, 0);
        end

        // Back-to-back: second command held on cmd_valid during the first
        burst(10'h040, 3, 1'b1, 10'h080, 2);
        burst(10'h080, 2, 1'b0, 10'h000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
